// File: rtl/panel_frame_writer.sv
// Assembles a 64x64 RGB565 byte stream into pixel writes for a two-bank framebuffer.
// The upper 32 rows go to bank 1 and the lower 32 rows to bank 2; every RAM-facing output is registered.
module panel_frame_writer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sof,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [10:0] o_ram_addr,
  output logic [15:0] o_ram_b1_data,
  output logic [15:0] o_ram_b2_data,
  output logic        o_ram_b1_we,
  output logic        o_ram_b2_we,
  output logic        o_frame_done,
  output logic        o_sync_err
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, WRITE} state_t;

  state_t      state_q, state_d;
  logic [11:0] pix_q, pix_d;
  logic [7:0]  first_q, first_d;
  logic [10:0] addr_d;
  logic [15:0] b1_data_d, b2_data_d, word;
  logic        b1_we_d, b2_we_d, done_d, err_d, xfer;

  // Handshake: a byte moves when i_byte_valid && o_byte_ready in the same cycle.
  // Ready is withheld only during the write cycle and while reset is asserted.
  assign o_byte_ready = i_rst_n && (state_q != WRITE);
  assign xfer         = i_byte_valid && o_byte_ready;
  assign word         = MSB_FIRST ? {first_q, i_byte} : {i_byte, first_q};

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    first_d   = first_q;
    addr_d    = o_ram_addr;
    b1_data_d = o_ram_b1_data;
    b2_data_d = o_ram_b2_data;
    b1_we_d   = 1'b0;
    b2_we_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (i_sof) begin
      // A new frame always wins; a frame already in progress is reported as truncated.
      pix_d = 12'd0;
      err_d = (state_q == BYTE1) || (state_q == WRITE) ||
              ((state_q == BYTE0) && (pix_q != 12'd0));
      if (xfer) begin
        first_d = i_byte;
        state_d = BYTE1;
      end else begin
        state_d = BYTE0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) err_d = 1'b1;
        end
        BYTE0: begin
          if (xfer) begin
            first_d = i_byte;
            state_d = BYTE1;
          end
        end
        BYTE1: begin
          if (xfer) begin
            addr_d = pix_q[10:0];
            if (pix_q[11]) begin
              b2_we_d   = 1'b1;
              b2_data_d = word;
            end else begin
              b1_we_d   = 1'b1;
              b1_data_d = word;
            end
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (pix_q == 12'd4095) begin
            done_d  = 1'b1;
            pix_d   = 12'd0;
            state_d = IDLE;
          end else begin
            pix_d   = pix_q + 12'd1;
            state_d = BYTE0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      pix_q         <= 12'd0;
      first_q       <= 8'd0;
      o_ram_addr    <= 11'd0;
      o_ram_b1_data <= 16'd0;
      o_ram_b2_data <= 16'd0;
      o_ram_b1_we   <= 1'b0;
      o_ram_b2_we   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_sync_err    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      first_q       <= first_d;
      o_ram_addr    <= addr_d;
      o_ram_b1_data <= b1_data_d;
      o_ram_b2_data <= b2_data_d;
      o_ram_b1_we   <= b1_we_d;
      o_ram_b2_we   <= b2_we_d;
      o_frame_done  <= done_d;
      o_sync_err    <= err_d;
    end
  end

endmodule
